// File: rtl/test_session_ctrl.sv
// Test session sequencer: arms checkers, starts and stops generators for a
// fixed window, waits for in-flight frames to drain, then snapshots the
// per-port checker results. All outputs are registered.
module test_session_ctrl #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned RES_WIDTH = 256
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_start,
   input  logic                           cmd_abort,
   input  logic [NUM_PORTS-1:0]           port_mask,
   input  logic [31:0]                    duration,
   input  logic [15:0]                    drain_cycles,
   input  logic [NUM_PORTS-1:0]           gen_ready,
   input  logic [NUM_PORTS-1:0]           chk_ready,
   output logic [NUM_PORTS-1:0]           gen_start,
   output logic [NUM_PORTS-1:0]           gen_stop,
   output logic [NUM_PORTS-1:0]           chk_start,
   output logic [NUM_PORTS-1:0]           chk_stop,
   input  logic [NUM_PORTS*RES_WIDTH-1:0] chk_result,
   output logic [NUM_PORTS*RES_WIDTH-1:0] snap_result,
   output logic                           busy,
   output logic                           done,
   output logic                           aborted,
   output logic [31:0]                    elapsed
);

   typedef enum logic [2:0] {
      StIdle,
      StWaitReady,
      StArm,
      StRun,
      StDrain,
      StSnap,
      StDone
   } state_e;

   state_e               state;
   logic [NUM_PORTS-1:0] mask_q;
   logic [31:0]          dur_q;
   logic [15:0]          drain_q;
   logic [15:0]          drain_cnt;

   logic [31:0]          run_len;
   logic                 last_run;
   logic                 all_ready;
   logic                 abort_ok;

   // Decode run length, readiness of masked ports and abort acceptance.
   always_comb begin
      // A zero duration still runs generators for one cycle.
      run_len   = (dur_q == 32'd0) ? 32'd1 : dur_q;
      // elapsed is cleared at start, so it doubles as the RUN cycle counter.
      last_run  = (elapsed == run_len - 32'd1);
      all_ready = &((gen_ready & chk_ready) | ~mask_q);
      // busy mirrors WAIT_READY..SNAP, which is exactly where abort applies.
      abort_ok  = cmd_abort && busy;
   end

   // Session FSM with registered pulses, status and result snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         mask_q      <= '0;
         dur_q       <= '0;
         drain_q     <= '0;
         drain_cnt   <= '0;
         gen_start   <= '0;
         gen_stop    <= '0;
         chk_start   <= '0;
         chk_stop    <= '0;
         snap_result <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         elapsed     <= '0;
      end else begin
         gen_start <= '0;
         gen_stop  <= '0;
         chk_start <= '0;
         chk_stop  <= '0;
         if (abort_ok) begin
            // Abort wins over everything in flight, including the SNAP copy.
            gen_stop <= mask_q;
            chk_stop <= mask_q;
            aborted  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            state    <= StIdle;
         end else begin
            unique case (state)
               StIdle, StDone: begin
                  if (cmd_start && (port_mask != '0)) begin
                     mask_q  <= port_mask;
                     dur_q   <= duration;
                     drain_q <= drain_cycles;
                     aborted <= 1'b0;
                     elapsed <= '0;
                     busy    <= 1'b1;
                     done    <= 1'b0;
                     state   <= StWaitReady;
                  end
               end
               StWaitReady: begin
                  if (all_ready) begin
                     chk_start <= mask_q;
                     state     <= StArm;
                  end
               end
               StArm: begin
                  gen_start <= mask_q;
                  state     <= StRun;
               end
               StRun: begin
                  if (elapsed != 32'hFFFF_FFFF) begin
                     elapsed <= elapsed + 32'd1;
                  end
                  if (last_run) begin
                     gen_stop <= mask_q;
                     if (drain_q == 16'd0) begin
                        chk_stop <= mask_q;
                        state    <= StSnap;
                     end else begin
                        drain_cnt <= 16'd1;
                        state     <= StDrain;
                     end
                  end
               end
               StDrain: begin
                  if (drain_cnt == drain_q) begin
                     chk_stop <= mask_q;
                     state    <= StSnap;
                  end else begin
                     drain_cnt <= drain_cnt + 16'd1;
                  end
               end
               StSnap: begin
                  for (int i = 0; i < int'(NUM_PORTS); i++) begin
                     snap_result[i*RES_WIDTH +: RES_WIDTH] <=
                        mask_q[i] ? chk_result[i*RES_WIDTH +: RES_WIDTH] : '0;
                  end
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StDone;
               end
               default: begin
                  state <= StIdle;
               end
            endcase
         end
      end
   end

endmodule
